// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and pin count shared by the GPIO controller and its bench.
package gpio_pkg;
   localparam int GPIO_WIDTH = 16;
   localparam logic [2:0] GPIO_DIR      = 3'd0;
   localparam logic [2:0] GPIO_OUT      = 3'd1;
   localparam logic [2:0] GPIO_IN       = 3'd2;
   localparam logic [2:0] GPIO_EDGE     = 3'd3;
   localparam logic [2:0] GPIO_EN       = 3'd4;
   localparam logic [2:0] GPIO_PRESCALE = 3'd5;
endpackage

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: two-flop synchronizer plus strobe-paced debounce for one pin.
module gpio_pin_filter #(
   parameter int FILT_SAMPLES = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   input  logic i_strobe,
   output logic o_filt,
   output logic o_chg
);
   localparam int CW = $clog2(FILT_SAMPLES + 1);
   logic [1:0] sync_q, sync_d;
   logic filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      sync_d = {sync_q[0], i_pin};
      o_chg  = i_strobe && (sync_q[1] != filt_q) && (cnt_q == CW'(FILT_SAMPLES - 1));
      filt_d = o_chg ? sync_q[1] : filt_q;
      cnt_d  = !i_strobe ? cnt_q : (sync_q[1] == filt_q || o_chg) ? '0 : cnt_q + CW'(1);
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         sync_q <= '0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   assign o_filt = filt_q;
endmodule

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO register file with debounced inputs, sticky edge flags
// and a masked level interrupt.
module gpio_port
   import gpio_pkg::*;
#(
   parameter int          WIDTH        = GPIO_WIDTH,
   parameter int          FILT_SAMPLES = 3,
   parameter logic [15:0] PRESCALE_RST = 16'd0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [2:0]       i_memAddr,
   input  logic [15:0]      i_memDataIn,
   input  logic             i_memWrEn,
   output logic [15:0]      o_memDataOut,
   input  logic [WIDTH-1:0] i_gpioPins,
   output logic [WIDTH-1:0] o_gpioDrive,
   output logic [WIDTH-1:0] o_gpioOe,
   output logic             o_intr
);
   logic [WIDTH-1:0] dir_q, dir_d, out_q, out_d, edge_q, edge_d, en_q, en_d;
   logic [WIDTH-1:0] filt, chg;
   logic [15:0] pre_q, pre_d, pcnt_q, pcnt_d;
   logic intr_q, intr_d, strobe;
   gpio_pin_filter #(.FILT_SAMPLES(FILT_SAMPLES)) u_filt [WIDTH-1:0] (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_pin    (i_gpioPins),
      .i_strobe ({WIDTH{strobe}}),
      .o_filt   (filt),
      .o_chg    (chg)
   );
   always_comb begin
      strobe = pcnt_q == pre_q;
      dir_d  = (i_memWrEn && i_memAddr == GPIO_DIR) ? i_memDataIn[WIDTH-1:0] : dir_q;
      out_d  = (i_memWrEn && i_memAddr == GPIO_OUT) ? i_memDataIn[WIDTH-1:0] : out_q;
      en_d   = (i_memWrEn && i_memAddr == GPIO_EN) ? i_memDataIn[WIDTH-1:0] : en_q;
      pre_d  = (i_memWrEn && i_memAddr == GPIO_PRESCALE) ? i_memDataIn : pre_q;
      // a new edge in the same cycle as its W1C clear keeps the flag set
      edge_d = (edge_q & ~((i_memWrEn && i_memAddr == GPIO_EDGE) ? i_memDataIn[WIDTH-1:0] : '0)) | chg;
      pcnt_d = ((i_memWrEn && i_memAddr == GPIO_PRESCALE) || strobe) ? 16'd0 : pcnt_q + 16'd1;
      intr_d = |(edge_q & en_q);
      o_memDataOut = (i_memAddr == GPIO_DIR)      ? 16'(dir_q)  :
                     (i_memAddr == GPIO_OUT)      ? 16'(out_q)  :
                     (i_memAddr == GPIO_IN)       ? 16'(filt)   :
                     (i_memAddr == GPIO_EDGE)     ? 16'(edge_q) :
                     (i_memAddr == GPIO_EN)       ? 16'(en_q)   :
                     (i_memAddr == GPIO_PRESCALE) ? pre_q       : 16'd0;
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         dir_q  <= '0;
         out_q  <= '0;
         edge_q <= '0;
         en_q   <= '0;
         pre_q  <= PRESCALE_RST;
         pcnt_q <= '0;
         intr_q <= 1'b0;
      end else begin
         dir_q  <= dir_d;
         out_q  <= out_d;
         edge_q <= edge_d;
         en_q   <= en_d;
         pre_q  <= pre_d;
         pcnt_q <= pcnt_d;
         intr_q <= intr_d;
      end
   assign o_gpioOe    = dir_q;
   assign o_gpioDrive = out_q;
   assign o_intr      = intr_q;
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed plan steps plus a randomized phase, checked against a
// behavioural model built from pin history and consecutive-sample run lengths.
module tb_gpio_port;
   import gpio_pkg::*;
   localparam int FS = 3;
   logic clk = 1'b0, rst = 1'b0;
   logic [2:0] addr = '0;
   logic [15:0] din = '0, dout, pins = '0, drive, oe;
   logic we = 1'b0, intr;
   int checks = 0, errors = 0;
   gpio_port #(.WIDTH(16), .FILT_SAMPLES(FS), .PRESCALE_RST(16'd0)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_memAddr    (addr),
      .i_memDataIn  (din),
      .i_memWrEn    (we),
      .o_memDataOut (dout),
      .i_gpioPins   (pins),
      .o_gpioDrive  (drive),
      .o_gpioOe     (oe),
      .o_intr       (intr)
   );
   always #5 clk = ~clk;
   // model state: pin seen two edges ago is what the filter judges
   logic [15:0] m_dir = '0, m_out = '0, m_edge = '0, m_en = '0, m_pre = '0, m_pcnt = '0;
   logic [15:0] m_h1 = '0, m_h2 = '0, m_filt = '0, m_sync, m_new;
   logic m_intr = 1'b0, m_stb;
   int m_run [16];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dir = '0; m_out = '0; m_edge = '0; m_en = '0; m_pre = '0; m_pcnt = '0;
         m_h1 = '0; m_h2 = '0; m_filt = '0; m_intr = 1'b0;
         for (int i = 0; i < 16; i++) m_run[i] = 0;
      end else begin
         m_stb = (m_pcnt == m_pre);
         m_sync = m_h2; m_h2 = m_h1; m_h1 = pins;
         m_new = '0;
         if (m_stb)
            for (int i = 0; i < 16; i++)
               if (m_sync[i] != m_filt[i]) begin
                  m_run[i]++;
                  if (m_run[i] == FS) begin
                     m_filt[i] = m_sync[i];
                     m_new[i] = 1'b1;
                     m_run[i] = 0;
                  end
               end else m_run[i] = 0;
         m_intr = |(m_edge & m_en);
         if (we && addr == 3'd3) m_edge = m_edge & ~din;
         m_edge = m_edge | m_new;
         m_pcnt = (we && addr == 3'd5) ? 16'd0 : m_stb ? 16'd0 : m_pcnt + 16'd1;
         if (we && addr == 3'd0) m_dir = din;
         if (we && addr == 3'd1) m_out = din;
         if (we && addr == 3'd4) m_en = din;
         if (we && addr == 3'd5) m_pre = din;
      end
   end
   function automatic logic [15:0] m_read(input logic [2:0] a);
      return a == 3'd0 ? m_dir : a == 3'd1 ? m_out : a == 3'd2 ? m_filt :
             a == 3'd3 ? m_edge : a == 3'd4 ? m_en : a == 3'd5 ? m_pre : 16'd0;
   endfunction
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic compare_all();
      chk("oe", oe, m_dir);
      chk("drive", drive, m_out);
      chk("intr", {15'd0, intr}, {15'd0, m_intr});
      chk("rdata", dout, m_read(addr));
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      addr = a; din = d; we = 1'b1;
      step();
      we = 1'b0;
   endtask
   task automatic rd(input logic [2:0] a, output logic [15:0] v);
      addr = a;
      #1 v = dout;
   endtask
   logic [15:0] v;
   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_oe", oe, 16'h0);
      chk("rst_drive", drive, 16'h0);
      chk("rst_intr", {15'd0, intr}, 16'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step();
      // register write/read and unmapped window
      wr(GPIO_DIR, 16'h00FF);
      chk("oe_after_wr", oe, 16'h00FF);
      wr(GPIO_OUT, 16'h00A5);
      chk("drive_after_wr", drive, 16'h00A5);
      rd(GPIO_DIR, v); chk("rd_dir", v, 16'h00FF);
      rd(GPIO_OUT, v); chk("rd_out", v, 16'h00A5);
      wr(3'd6, 16'hFFFF);
      wr(GPIO_IN, 16'hFFFF);
      rd(3'd6, v); chk("rd_addr6", v, 16'h0);
      rd(GPIO_IN, v); chk("rd_in_ro", v, 16'h0);
      // five-edge latency on pin 3 and the interrupt one edge later
      wr(GPIO_EN, 16'h0008);
      pins[3] = 1'b1;
      repeat (4) step();
      rd(GPIO_IN, v); chk("in3_edge4", {15'd0, v[3]}, 16'd0);
      step();
      rd(GPIO_IN, v); chk("in3_edge5", {15'd0, v[3]}, 16'd1);
      rd(GPIO_EDGE, v); chk("edge3_edge5", {15'd0, v[3]}, 16'd1);
      chk("intr_not_yet", {15'd0, intr}, 16'd0);
      step();
      chk("intr_set", {15'd0, intr}, 16'd1);
      // two-clock glitch on pin 7 is rejected
      wr(GPIO_EDGE, 16'h0008);
      wr(GPIO_EN, 16'h0080);
      step();
      chk("intr_cleared", {15'd0, intr}, 16'd0);
      pins[7] = 1'b1;
      repeat (2) step();
      pins[7] = 1'b0;
      repeat (6) step();
      rd(GPIO_IN, v); chk("glitch_in7", {15'd0, v[7]}, 16'd0);
      rd(GPIO_EDGE, v); chk("glitch_edge", v, 16'h0);
      chk("glitch_intr", {15'd0, intr}, 16'd0);
      // prescaled sampling: three strobes five clocks apart
      wr(GPIO_PRESCALE, 16'd4);
      pins[0] = 1'b1;
      repeat (14) step();
      rd(GPIO_IN, v); chk("pre_in0_early", {15'd0, v[0]}, 16'd0);
      step();
      rd(GPIO_IN, v); chk("pre_in0_set", {15'd0, v[0]}, 16'd1);
      wr(GPIO_PRESCALE, 16'd0);
      // W1C colliding with a fresh edge on pin 3
      pins[3] = 1'b0;
      repeat (5) step();
      rd(GPIO_EDGE, v); chk("edge_0009", v, 16'h0009);
      wr(GPIO_EN, 16'h0008);
      pins[3] = 1'b1;
      repeat (4) step();
      wr(GPIO_EDGE, 16'h0001);
      rd(GPIO_EDGE, v); chk("edge_set_wins", v, 16'h0008);
      chk("intr_en3", {15'd0, intr}, 16'd1);
      wr(GPIO_EN, 16'h0000);
      chk("intr_lag", {15'd0, intr}, 16'd1);
      step();
      chk("intr_masked", {15'd0, intr}, 16'd0);
      wr(GPIO_EN, 16'h0008);
      step();
      chk("intr_unmasked", {15'd0, intr}, 16'd1);
      // asynchronous reset in the middle of a debounce
      wr(GPIO_DIR, 16'hFFFF);
      wr(GPIO_OUT, 16'h1234);
      wr(GPIO_EN, 16'hFFFF);
      pins[5] = 1'b1;
      repeat (2) step();
      #1 rst = 1'b1;
      #1;
      chk("arst_oe", oe, 16'h0);
      chk("arst_drive", drive, 16'h0);
      chk("arst_intr", {15'd0, intr}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) step();
      rd(GPIO_IN, v); chk("post_rst_in5_early", {15'd0, v[5]}, 16'd0);
      step();
      rd(GPIO_IN, v); chk("post_rst_in5", {15'd0, v[5]}, 16'd1);
      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 5) == 0) pins = pins ^ (16'd1 << $urandom_range(0, 15));
         addr = 3'($urandom_range(0, 7));
         din = (addr == GPIO_PRESCALE) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         we = ($urandom_range(0, 3) == 0);
         step();
         we = 1'b0;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
Memory-mapped GPIO controller sitting downstream of the memory controller's mapped-register write/read path. It owns the 16 general-purpose pins that the top level currently ties off.
- Drives output value and output-enable per pin; the top level performs the tristate.
- Synchronizes and debounces pin inputs.
- Captures per-pin edge events into sticky flags and raises a single interrupt line to the core.

Parameters:
WIDTH, 16, number of GPIO pins
FILT_SAMPLES, 3, consecutive differing samples required before the filtered input changes (min 1)
PRESCALE_RST, 0, reset value of the sample prescaler register

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_memAddr  input  3  register offset within the GPIO mapped window
i_memDataIn  input  16  write data from the memory bus
i_memWrEn  input  1  write strobe, qualified by mapped-address decode upstream
o_memDataOut  output  16  read data for the addressed register (combinational)
i_gpioPins  input  WIDTH  raw pin levels (asynchronous)
o_gpioDrive  output  WIDTH  output level per pin
o_gpioOe  output  WIDTH  1 = top level drives the pin, 0 = Z
o_intr  output  1  level interrupt to the core

Behaviour:
- Reset is asynchronous and active-high; one clock domain (i_clk). Every register is cleared on i_rst with no clock needed. Reset values:
  - DIR = 0, OUT = 0, EDGE = 0, EN = 0, PRESCALE = PRESCALE_RST
  - synchronizers = 0, filtered input = 0, filter counters = 0, prescale counter = 0
  - Outputs therefore reset to o_gpioDrive = 0, o_gpioOe = 0, o_intr = 0.
- Register map (i_memAddr):
  - 0 DIR: R/W.
  - 1 OUT: R/W.
  - 2 IN: RO; returns the filtered input.
  - 3 EDGE: R/W1C.
  - 4 EN: R/W; interrupt mask.
  - 5 PRESCALE: R/W, 16 bits.
  - 6 and 7: read 0; writes ignored.
  - Writes to IN are ignored.
- Register writes take effect on the rising edge where i_memWrEn = 1. o_gpioOe = DIR and o_gpioDrive = OUT, both straight from flops, so a write is visible one edge later.
- Reads are combinational from current register state. A read in the same cycle as a write returns the old value.
- Sample strobe:
  - The prescale counter increments each clock.
  - When counter == PRESCALE, the strobe asserts for that cycle and the counter wraps to 0.
  - PRESCALE = 0 gives a strobe every cycle.
  - Writing PRESCALE clears the counter.
- Per-pin input path:
  - Two-flop synchronizer feeds sync.
  - On each strobe: if sync == filt, cnt <= 0. Otherwise cnt increments; when cnt reaches FILT_SAMPLES-1 (i.e. on the FILT_SAMPLES-th consecutive differing strobe), filt <= sync and cnt <= 0.
  - No strobe: everything holds.
- Latency: with PRESCALE = 0 and FILT_SAMPLES = 3, a clean pin change is reflected in IN and EDGE after the 5th rising edge following the change (2 synchronizer edges + 3 sample edges).
- Glitch rejection: a glitch shorter than FILT_SAMPLES strobes never reaches filt.
- Edge flags:
  - EDGE[i] sets on the same edge that filt[i] changes, in either direction.
  - Flags are sticky until cleared by writing 1 to that bit of EDGE; writing 0 has no effect.
  - If a set and a W1C clear hit the same cycle, set wins.
- Pins with DIR = 1 still sample the pin, so IN reflects the driven level, subject to the same filtering.
- o_intr = |(EDGE & EN), registered, so it asserts one edge after the flag sets. Changing EN or clearing EDGE updates o_intr on the following edge.
- Reset asserted mid-filter or mid-prescale discards all partial counts.

Decomposition:
- Shared package (gpio_pkg): register offset constants GPIO_DIR = 3'd0 through GPIO_PRESCALE = 3'd5, and GPIO_WIDTH = 16.
- Sub-module gpio_pin_filter, one instance per pin (instance array WIDTH wide):
  - contains the synchronizer, debounce counter and filt flop;
  - inputs: i_clk, i_rst, raw pin, strobe;
  - outputs: filt, a one-cycle change pulse.
- Top gpio_port holds the register file, prescaler, EDGE/EN logic and read mux.

Test Plan:
1. Reset, then write DIR = 16'h00FF and OUT = 16'h00A5 -> after 1 edge o_gpioOe = 16'h00FF, o_gpioDrive = 16'h00A5; reads return the same; read of addr 6 returns 0.
2. PRESCALE = 0, pin 3 raised and held -> IN[3] = 1 and EDGE[3] = 1 after the 5th edge; with EN[3] = 1, o_intr = 1 one edge later.
3. Pin 7 pulsed high for 2 clocks (PRESCALE = 0) -> IN[7] stays 0, EDGE[7] stays 0, o_intr stays 0.
4. PRESCALE = 4, pin 0 raised -> filtered change only after 3 strobes spaced 5 clocks apart; IN[0] unchanged before then.
5. EDGE = 16'h0009; write 16'h0001 to EDGE while pin 3 fires a new edge in the same cycle -> EDGE = 16'h0008; o_intr follows EN.
6. i_rst asserted between edges mid-debounce with DIR/OUT/EN nonzero -> all outputs 0 immediately (before the next clock edge); after release, a previously pending pin change needs a full 5 edges to appear.
